// File: rtl/pipe_pkg.sv
// Shared pipeline types: per-stage destination-register control bundle and the
// dependence test used by both the hazard scoreboard and the forwarding unit.
package pipe_pkg;

  localparam int unsigned AW = 5;

  typedef struct packed {
    logic          reg_w;
    logic          mem_read;
    logic [AW-1:0] rd;
  } stage_ctrl_t;

  localparam stage_ctrl_t StageNop = '{reg_w: 1'b0, mem_read: 1'b0, rd: '0};

  // $0 is hardwired, so a write to it never creates a dependence.
  function automatic logic dep_match(input logic [AW-1:0] r,
                                     input logic [AW-1:0] rs,
                                     input logic [AW-1:0] rt,
                                     input logic          uses_rs,
                                     input logic          uses_rt);
    return (r != '0) && ((uses_rs && (r == rs)) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/destination info in, pipeline stall/flush controls and tracked
// stage destination state out.
interface hazard_scoreboard_if #(
  parameter int unsigned AW    = pipe_pkg::AW,
  parameter int unsigned CNT_W = 16
);
  logic [AW-1:0]    IdRs;
  logic [AW-1:0]    IdRt;
  logic             IdUsesRs;
  logic             IdUsesRt;
  logic             IdRegW;
  logic             IdMemRead;
  logic [AW-1:0]    IdRd;
  logic             IdBranch;
  logic             BranchTaken;
  logic             ICacheStall;
  logic             DCacheStall;

  logic             PcWrite;
  logic             IfIdWrite;
  logic             IfIdFlush;
  logic             IdExBubble;
  logic             StallAll;
  logic             IdExRegW;
  logic             IdExMemRead;
  logic [AW-1:0]    IdExRd;
  logic             ExMemRegW;
  logic             ExMemMemRead;
  logic [AW-1:0]    ExMemRd;
  logic             MemWbRegW;
  logic [AW-1:0]    MemWbRd;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IdRs, IdRt, IdUsesRs, IdUsesRt, IdRegW, IdMemRead, IdRd, IdBranch,
           BranchTaken, ICacheStall, DCacheStall,
    input  PcWrite, IfIdWrite, IfIdFlush, IdExBubble, StallAll, IdExRegW, IdExMemRead,
           IdExRd, ExMemRegW, ExMemMemRead, ExMemRd, MemWbRegW, MemWbRd, StallCount
  );

  modport slave (
    input  IdRs, IdRt, IdUsesRs, IdUsesRt, IdRegW, IdMemRead, IdRd, IdBranch,
           BranchTaken, ICacheStall, DCacheStall,
    output PcWrite, IfIdWrite, IfIdFlush, IdExBubble, StallAll, IdExRegW, IdExMemRead,
           IdExRd, ExMemRegW, ExMemMemRead, ExMemRd, MemWbRegW, MemWbRd, StallCount
  );
endinterface

// File: rtl/stage_ctrl_reg.sv
// One pipeline stage's destination-control register; clear wins over load and
// both are gated by the enable.
module stage_ctrl_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  stage_ctrl_t d_i,
  output stage_ctrl_t q_o
);

  stage_ctrl_t ctrl_q, ctrl_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (en_i) begin
      ctrl_d = clr_i ? StageNop : d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= StageNop;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign q_o = ctrl_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination-register state through ID/EX, EX/MEM, MEM/WB and raises the
// stalls, bubbles and flushes that forwarding alone cannot resolve.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter bit          BRANCH_IN_ID = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  stage_ctrl_t      id_ctrl, idex_q, exmem_q, memwb_q;
  logic             idex_match, exmem_match;
  logic             load_use, br_haz, cache_stall, data_stall, stage_en;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_memwb_mem_read;

  assign id_ctrl = '{reg_w: bus.IdRegW, mem_read: bus.IdMemRead, rd: bus.IdRd};

  always_comb begin
    idex_match  = dep_match(idex_q.rd, bus.IdRs, bus.IdRt, bus.IdUsesRs, bus.IdUsesRt);
    exmem_match = dep_match(exmem_q.rd, bus.IdRs, bus.IdRt, bus.IdUsesRs, bus.IdUsesRt);
    load_use    = idex_q.mem_read && idex_q.reg_w && idex_match;
    // A branch compared in ID needs ALU results one stage earlier and load data
    // two stages earlier than the forwarding paths can deliver.
    br_haz      = BRANCH_IN_ID && bus.IdBranch &&
                  ((idex_q.reg_w && idex_match) ||
                   (exmem_q.mem_read && exmem_q.reg_w && exmem_match));
    cache_stall = bus.ICacheStall || bus.DCacheStall;
    data_stall  = load_use || br_haz;
    stage_en    = !cache_stall;
  end

  assign bus.StallAll   = cache_stall;
  assign bus.PcWrite    = !(cache_stall || data_stall);
  assign bus.IfIdWrite  = !(cache_stall || data_stall);
  assign bus.IdExBubble = !cache_stall && data_stall;
  assign bus.IfIdFlush  = !cache_stall && !data_stall && bus.BranchTaken;

  stage_ctrl_reg u_idex (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stage_en),
    .clr_i (data_stall),
    .d_i   (id_ctrl),
    .q_o   (idex_q)
  );

  stage_ctrl_reg u_exmem (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stage_en),
    .clr_i (1'b0),
    .d_i   (idex_q),
    .q_o   (exmem_q)
  );

  stage_ctrl_reg u_memwb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (stage_en),
    .clr_i (1'b0),
    .d_i   (exmem_q),
    .q_o   (memwb_q)
  );

  assign unused_memwb_mem_read = memwb_q.mem_read;

  assign bus.IdExRegW     = idex_q.reg_w;
  assign bus.IdExMemRead  = idex_q.mem_read;
  assign bus.IdExRd       = idex_q.rd;
  assign bus.ExMemRegW    = exmem_q.reg_w;
  assign bus.ExMemMemRead = exmem_q.mem_read;
  assign bus.ExMemRd      = exmem_q.rd;
  assign bus.MemWbRegW    = memwb_q.reg_w;
  assign bus.MemWbRd      = memwb_q.rd;

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.PcWrite && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: each scenario queues the expected
// control vector per cycle and compares it against the DUT mid-cycle.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

  localparam int unsigned CntW    = 6;
  localparam logic [4:0]  NoStall = 5'b11000;  // {PcWrite,IfIdWrite,Flush,Bubble,StallAll}
  localparam logic [4:0]  DStall  = 5'b00010;
  localparam logic [4:0]  CStall  = 5'b00001;
  localparam logic [4:0]  Flush   = 5'b11100;

  typedef struct packed {
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       regw;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       bt;
    logic       ic;
    logic       dc;
    logic [4:0] exp;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;
  logic [CntW-1:0] cnt_q_exp[$];
  logic [CntW-1:0] ce;
  logic [4:0] ctrl_obs;

  hazard_scoreboard_if #(.AW(5), .CNT_W(CntW)) bus ();

  hazard_scoreboard #(.CNT_W(CntW), .BRANCH_IN_ID(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {bus.PcWrite, bus.IfIdWrite, bus.IfIdFlush, bus.IdExBubble, bus.StallAll};

  function automatic step_t mk(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                               input logic urt, input logic regw, input logic mr,
                               input logic [4:0] rd, input logic br, input logic [4:0] exp);
    step_t s;
    s = '0;
    s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
    s.regw = regw; s.mr = mr; s.rd = rd; s.br = br; s.exp = exp;
    return s;
  endfunction

  task automatic apply(input step_t s);
    bus.IdRs = s.rs;  bus.IdUsesRs = s.urs;
    bus.IdRt = s.rt;  bus.IdUsesRt = s.urt;
    bus.IdRegW = s.regw; bus.IdMemRead = s.mr; bus.IdRd = s.rd;
    bus.IdBranch = s.br; bus.BranchTaken = s.bt;
    bus.ICacheStall = s.ic; bus.DCacheStall = s.dc;
  endtask

  task automatic do_reset();
    apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NoStall));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (ctrl_obs !== NoStall) $display("FAIL reset_ctrl: got %b want %b", ctrl_obs, NoStall);
    else passed++;
    checks++;
    if ({bus.IdExRegW, bus.IdExMemRead, bus.IdExRd, bus.ExMemRegW, bus.ExMemMemRead,
         bus.ExMemRd, bus.MemWbRegW, bus.MemWbRd} !== 20'd0)
      $display("FAIL reset_tracked: got IdExRd=%0d ExMemRd=%0d MemWbRd=%0d want all 0",
               bus.IdExRd, bus.ExMemRd, bus.MemWbRd);
    else passed++;
    checks++;
    if (bus.StallCount !== 6'd0) $display("FAIL reset_count: got %0d want 0", bus.StallCount);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    step_t s[3];
    do_reset();
    s[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, NoStall);  // lw $8
    s[1] = mk(5'd8, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, DStall);   // add $9,$8,$1
    s[2] = s[1]; s[2].exp = NoStall;
    for (int i = 0; i < 3; i++) begin
      apply(s[i]); exp_q.push_back(s[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL load_use_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      if (i == 2) begin
        checks++;
        if ({bus.IdExRegW, bus.ExMemMemRead, bus.ExMemRd, bus.StallCount} !==
            {1'b0, 1'b1, 5'd8, 6'd1})
          $display("FAIL load_use_state: got IdExRegW=%b ExMemMR=%b ExMemRd=%0d cnt=%0d want 0 1 8 1",
                   bus.IdExRegW, bus.ExMemMemRead, bus.ExMemRd, bus.StallCount);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_hazard();
    step_t s[4];
    step_t b[3];
    do_reset();
    s[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, NoStall);  // lw $8
    s[1] = mk(5'd8, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, DStall);   // beq $8,$0
    s[2] = s[1];
    s[3] = s[1]; s[3].exp = NoStall;
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(s[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL br_load_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      @(posedge clk); #1;
    end
    do_reset();
    b[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, NoStall);  // add $8
    b[1] = s[1];
    b[2] = s[1]; b[2].exp = NoStall;
    for (int i = 0; i < 3; i++) begin
      apply(b[i]); exp_q.push_back(b[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL br_alu_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_unused();
    step_t s[4];
    do_reset();
    s[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, NoStall);  // lw $0
    s[1] = mk(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, NoStall);  // reads $0
    s[2] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, NoStall);  // lw $8
    s[3] = mk(5'd1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, NoStall);  // rt=8 not used
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(s[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL zero_unused_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      @(posedge clk); #1;
    end
    @(negedge clk); checks++;
    if (bus.StallCount !== 6'd0) $display("FAIL zero_unused_count: got %0d want 0", bus.StallCount);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_cache_stall();
    step_t s[7];
    do_reset();
    s[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, NoStall);  // lw $8
    for (int i = 1; i < 7; i++) s[i] = mk(5'd8, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, CStall);
    for (int i = 1; i < 5; i++) s[i].dc = 1'b1;
    s[5].exp = DStall;
    s[6].exp = NoStall;
    for (int i = 0; i < 7; i++) begin
      apply(s[i]); exp_q.push_back(s[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL cache_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      if (i >= 1 && i <= 4) begin
        checks++;
        if ({bus.IdExMemRead, bus.IdExRd, bus.ExMemRd} !== {1'b1, 5'd8, 5'd0})
          $display("FAIL cache_frozen step %0d: got IdExMR=%b IdExRd=%0d ExMemRd=%0d want 1 8 0",
                   i, bus.IdExMemRead, bus.IdExRd, bus.ExMemRd);
        else passed++;
      end
      if (i == 6) begin
        checks++;
        if (bus.StallCount !== 6'd5) $display("FAIL cache_count: got %0d want 5", bus.StallCount);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_taken();
    step_t s[5];
    do_reset();
    s[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, Flush);   // jal
    s[0].bt = 1'b1;
    s[1] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NoStall);
    s[2] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, NoStall);  // lw $8
    s[3] = mk(5'd8, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, DStall);
    s[3].bt = 1'b1;
    s[4] = s[3]; s[4].bt = 1'b0; s[4].exp = NoStall;
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); exp_q.push_back(s[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL taken_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      if (i == 1) begin
        checks++;
        if ({bus.IdExRegW, bus.IdExRd} !== {1'b1, 5'd31})
          $display("FAIL taken_idex: got RegW=%b Rd=%0d want 1 31", bus.IdExRegW, bus.IdExRd);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t s[4];
    do_reset();
    s[0] = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, NoStall);
    s[1] = mk(5'd8, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, DStall);
    s[2] = s[1];
    s[3] = s[1]; s[3].exp = NoStall;
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(s[i].exp);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (ctrl_obs !== e) $display("FAIL rst_mid_ctrl step %0d: got %b want %b", i, ctrl_obs, e);
      else passed++;
      if (i == 2) begin
        #1 rst_n = 1'b0;
        #1 checks++;
        if ({bus.IdExRegW, bus.IdExMemRead, bus.IdExRd, bus.ExMemRegW, bus.ExMemMemRead,
             bus.ExMemRd, bus.MemWbRegW, bus.MemWbRd, bus.StallCount} !== 26'd0)
          $display("FAIL rst_mid_state: got ExMemRd=%0d cnt=%0d want 0 0", bus.ExMemRd,
                   bus.StallCount);
        else passed++;
        checks++;
        if (ctrl_obs !== NoStall) $display("FAIL rst_mid_ctrl_async: got %b want %b", ctrl_obs,
                                           NoStall);
        else passed++;
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    step_t s;
    do_reset();
    s = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, CStall);
    s.ic = 1'b1;
    apply(s);
    for (int i = 0; i <= 67; i++) begin
      cnt_q_exp.push_back((i > 63) ? 6'd63 : 6'(i));
      @(negedge clk); ce = cnt_q_exp.pop_front(); checks++;
      if (bus.StallCount !== ce) $display("FAIL saturate cycle %0d: got %0d want %0d", i,
                                          bus.StallCount, ce);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_zero_and_unused();
    test_cache_stall();
    test_branch_taken();
    test_reset_mid_stall();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Producer-side counterpart of the forwarding unit. It tracks destination-register state (RegWrite, MemRead, Rd) through the ID/EX, EX/MEM and MEM/WB stages and drives the ExMem/MemWb fields that the forwarding unit consumes. It also detects hazards that forwarding cannot cover (load-use, branch-in-ID operand dependence, cache stalls) and issues stall, bubble and flush controls to the 5-stage MIPS pipeline.

Parameters:
AW, 5, register-address width
CNT_W, 16, width of the saturating stall-cycle performance counter
BRANCH_IN_ID, 1, 1 = branches compare in ID, so branch operand hazard checks are enabled; 0 = those checks are disabled

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
IdRs  in  AW  rs of the instruction in ID
IdRt  in  AW  rt of the instruction in ID
IdUsesRs  in  1  ID instruction reads rs
IdUsesRt  in  1  ID instruction reads rt
IdRegW  in  1  ID instruction writes a register
IdMemRead  in  1  ID instruction is a load
IdRd  in  AW  final destination of the ID instruction (after rt/rd/$31 mux)
IdBranch  in  1  ID instruction is a conditional branch
BranchTaken  in  1  branch or jump resolved taken in ID
ICacheStall  in  1  instruction-cache miss in progress
DCacheStall  in  1  data-cache miss in progress
PcWrite  out  1  PC update enable
IfIdWrite  out  1  IF/ID register enable
IfIdFlush  out  1  zero IF/ID on the next edge
IdExBubble  out  1  insert a NOP into ID/EX on the next edge
StallAll  out  1  freeze all pipeline registers
IdExRegW, IdExMemRead  out  1 each  tracked ID/EX control bits
IdExRd  out  AW  tracked ID/EX destination register
ExMemRegW, ExMemMemRead  out  1 each  tracked EX/MEM control bits
ExMemRd  out  AW  tracked EX/MEM destination register
MemWbRegW  out  1  tracked MEM/WB control bit
MemWbRd  out  AW  tracked MEM/WB destination register
StallCount  out  CNT_W  saturating count of cycles where PcWrite=0

Behaviour:
- Reset: all tracked registers and StallCount are 0. Combinational outputs therefore reset to PcWrite=1, IfIdWrite=1, IfIdFlush=0, IdExBubble=0, StallAll=0.
- match(r) = (r != 0) && ((IdUsesRs && r == IdRs) || (IdUsesRt && r == IdRt)).
- loadUse = IdExMemRead && IdExRegW && match(IdExRd).
- brHaz = BRANCH_IN_ID && IdBranch && ((IdExRegW && match(IdExRd)) || (ExMemMemRead && ExMemRegW && match(ExMemRd))). A branch on a load result therefore stalls 2 cycles; a branch on an ALU result stalls 1 cycle.
- Priority, highest first:
  - cache: ICacheStall or DCacheStall. StallAll=1, PcWrite=0, IfIdWrite=0, no bubble, no flush. All tracked registers hold.
  - data: loadUse or brHaz. PcWrite=0, IfIdWrite=0, IdExBubble=1, IfIdFlush=0. IdEx* load 0; EX/MEM and MEM/WB shift normally.
  - branch: BranchTaken. IfIdFlush=1, PcWrite=1. Tracked registers shift normally and IdEx* load the branch's Id* fields.
  - none: all enables 1. The registers shift: MemWb<=ExMem, ExMem<=IdEx, IdEx<=Id*.
- BranchTaken during a data or cache stall is ignored. ID re-evaluates it after the stall clears.
- Rd=0 never causes a stall and never counts as a dependence.
- StallCount increments on every cycle with PcWrite=0 and holds at its all-ones value.
- rst_n asserted mid-stall clears all state immediately. The first cycle after release is a non-stall cycle.
- No other latency: all hazard outputs are combinational from the current tracked state and ID inputs.

Decomposition:
- Shared package pipe_pkg holds AW, the NOP control-bundle constant, and the stage-control typedef {RegW, MemRead, Rd}. The forwarding unit reuses this package.
- One natural sub-module, stage_ctrl_reg: a single stage control register with enable and clear inputs, instantiated three times.

Test Plan:
- lw $8 in EX, ID add $9,$8,$1 (IdUsesRs=1, IdRs=8) -> one cycle of PcWrite=0, IdExBubble=1. Next cycle IdExRegW=0, ExMemRd=8, ExMemMemRead=1, no stall. StallCount=1.
- beq $8,$0 in ID with lw $8 in EX -> 2 stall cycles (first IdEx, then ExMem match), 3rd cycle PcWrite=1. Repeat with add $8 in EX -> 1 stall cycle.
- lw $0 in EX, ID reads $0 -> no stall. ID add with IdUsesRt=0 and IdRt equal to the load's Rd -> no stall.
- DCacheStall high 4 cycles during a load-use hazard -> StallAll=1 and tracked registers frozen for 4 cycles, then the single load-use bubble follows. StallCount=5.
- BranchTaken with no hazard -> IfIdFlush=1 for exactly 1 cycle, PcWrite=1. BranchTaken coincident with loadUse -> IfIdFlush=0, bubble asserted.
- Reset pulse during the second branch stall cycle -> all tracked outputs 0 asynchronously, PcWrite=1 after release. Force 2^CNT_W+3 stall cycles -> StallCount saturates at the all-ones value.
